// File: rtl/regacc_pkg.sv
// Shared types and constants for the register-file access controller.
package regacc_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} regacc_state_t;

  // x0 is hard-wired: its index never produces a strobe.
  function automatic logic [NUM_REGS-1:0] reg_decode(input reg_idx_t idx);
    reg_decode = '0;
    if (idx != '0) reg_decode[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Requester-side transaction bus: per-requester request fields in, ack/read data out.
interface regfile_access_ctrl_if #(
  parameter int NUM_REQ = 2
);
  import regacc_pkg::*;

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0][REG_IDX_W-1:0] rs1_idx;
  logic [NUM_REQ-1:0][REG_IDX_W-1:0] rs2_idx;
  logic [NUM_REQ-1:0][REG_IDX_W-1:0] rd_idx;
  logic [NUM_REQ-1:0]                rd_we;
  logic [NUM_REQ-1:0][XLEN-1:0]      wdata;
  logic [NUM_REQ-1:0]                ack;
  logic [XLEN-1:0]                   rdata1;
  logic [XLEN-1:0]                   rdata2;

  modport master (
    output req, rs1_idx, rs2_idx, rd_idx, rd_we, wdata,
    input  ack, rdata1, rdata2
  );

  modport slave (
    input  req, rs1_idx, rs2_idx, rd_idx, rd_we, wdata,
    output ack, rdata1, rdata2
  );
endinterface

// File: rtl/regacc_rr_arbiter.sv
// One-hot grant among NUM_REQ requesters. REGACC_ROUND_ROBIN_EN selects round-robin,
// otherwise fixed priority with the lowest index winning.
module regacc_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_grant_en,
  output logic [NUM_REQ-1:0] o_grant
);
  logic w_found;

`ifdef REGACC_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // r_ptr is the highest-priority index: one past the last winner.
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_next_ptr;

  always_comb begin
    o_grant    = '0;
    w_found    = 1'b0;
    w_next_ptr = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (i >= int'(r_ptr))) begin
        o_grant[i] = i_grant_en;
        w_found    = 1'b1;
        w_next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_grant[i] = i_grant_en;
        w_found    = 1'b1;
        w_next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_ptr <= '0;
    else if (i_grant_en && w_found)
      r_ptr <= w_next_ptr;
  end
`else
  logic w_unused;
  assign w_unused = clk ^ reset_n;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_grant[i] = i_grant_en;
        w_found    = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences one read/write transaction at a time into the tristate-bus register file.
// Arbitration policy selected by REGACC_ROUND_ROBIN_EN (round-robin) or fixed priority when undefined.
module regfile_access_ctrl
  import regacc_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  regfile_access_ctrl_if.slave bus,
  output logic [NUM_REGS-1:0] o_rf_load,
  output logic [XLEN-1:0]     o_rf_wdata,
  output logic [NUM_REGS-1:0] o_rf_out0_en,
  output logic [NUM_REGS-1:0] o_rf_out1_en,
  input  logic [XLEN-1:0]     i_rf_bus0,
  input  logic [XLEN-1:0]     i_rf_bus1
);
  regacc_state_t       r_state;
  logic [NUM_REQ-1:0]  r_winner;
  logic [NUM_REQ-1:0]  r_ack;
  logic [XLEN-1:0]     r_rdata1;
  logic [XLEN-1:0]     r_rdata2;
  logic [NUM_REGS-1:0] r_rf_load;
  logic [XLEN-1:0]     r_rf_wdata;
  logic [NUM_REGS-1:0] r_out0_en;
  logic [NUM_REGS-1:0] r_out1_en;

  reg_idx_t            r_rs1;
  reg_idx_t            r_rs2;
  reg_idx_t            r_rd;
  logic                r_write;
  logic [XLEN-1:0]     r_wdata;

  logic                w_idle;
  logic                w_start;
  logic [NUM_REQ-1:0]  w_grant;
  reg_idx_t            w_rs1;
  reg_idx_t            w_rs2;
  reg_idx_t            w_rd;
  logic                w_we;
  logic [XLEN-1:0]     w_wdata;

  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle && (|bus.req);

  regacc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (bus.req),
    .i_grant_en (w_idle),
    .o_grant    (w_grant)
  );

  // One-hot grant steers the winner's fields.
  always_comb begin
    w_rs1   = '0;
    w_rs2   = '0;
    w_rd    = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_rs1   = w_rs1   | bus.rs1_idx[i];
        w_rs2   = w_rs2   | bus.rs2_idx[i];
        w_rd    = w_rd    | bus.rd_idx[i];
        w_we    = w_we    | bus.rd_we[i];
        w_wdata = w_wdata | bus.wdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_rd    <= w_rd;
      r_write <= w_we && (w_rd != '0);
      r_wdata <= w_wdata;
    end
  end

  // Strobes are loaded on the edge entering their state, so each is a clean register output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_winner   <= '0;
      r_ack      <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_rf_load  <= '0;
      r_rf_wdata <= '0;
      r_out0_en  <= '0;
      r_out1_en  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= '0;
          if (w_start) begin
            r_winner  <= w_grant;
            r_out0_en <= reg_decode(w_rs1);
            r_out1_en <= reg_decode(w_rs2);
            r_state   <= READ;
          end
        end
        READ: begin
          r_out0_en <= '0;
          r_out1_en <= '0;
          r_rdata1  <= (r_rs1 == '0) ? '0 : i_rf_bus0;
          r_rdata2  <= (r_rs2 == '0) ? '0 : i_rf_bus1;
          if (r_write) begin
            r_rf_load  <= reg_decode(r_rd);
            r_rf_wdata <= r_wdata;
            r_state    <= WRITE;
          end else begin
            r_ack   <= r_winner;
            r_state <= ACK;
          end
        end
        WRITE: begin
          r_rf_load  <= '0;
          r_rf_wdata <= '0;
          r_ack      <= r_winner;
          r_state    <= ACK;
        end
        ACK: begin
          r_ack   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.rdata1   = r_rdata1;
  assign bus.rdata2   = r_rdata2;
  assign o_rf_load    = r_rf_load;
  assign o_rf_wdata   = r_rf_wdata;
  assign o_rf_out0_en = r_out0_en;
  assign o_rf_out1_en = r_out1_en;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: negedge-commit register file model on tristate-style buses,
// transaction-level reference register array and arbitration model.
module tb_regfile_access_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rf_load, rf_wdata, rf_out0_en, rf_out1_en, rf_bus0, rf_bus1;

  logic [31:0] rf_phys [32];
  logic [31:0] ref_rf  [32];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [31:0] pre_val;

  int n_chk = 0;
  int n_err = 0;

  regfile_access_ctrl_if #(.NUM_REQ(2)) bus ();

  regfile_access_ctrl #(.NUM_REQ(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .o_rf_load    (rf_load),
    .o_rf_wdata   (rf_wdata),
    .o_rf_out0_en (rf_out0_en),
    .o_rf_out1_en (rf_out1_en),
    .i_rf_bus0    (rf_bus0),
    .i_rf_bus1    (rf_bus1)
  );

  always #5 clk = ~clk;

  // Register file: commits on negedge; an undriven bus reads as a distinctive pattern.
  always @(negedge clk) begin
    if (pre_we) rf_phys[pre_idx] <= pre_val;
    else
      for (int i = 0; i < 32; i++)
        if (rf_load[i]) rf_phys[i] <= rf_wdata;
  end

  always_comb begin
    rf_bus0 = 32'hA5A5_A5A5;
    rf_bus1 = 32'h5A5A_5A5A;
    for (int i = 0; i < 32; i++) begin
      if (rf_out0_en[i]) rf_bus0 = rf_phys[i];
      if (rf_out1_en[i]) rf_bus1 = rf_phys[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check_eq("onehot_load", 32'($onehot0(rf_load)), 32'd1);
    check_eq("onehot_en0",  32'($onehot0(rf_out0_en)), 32'd1);
    check_eq("onehot_en1",  32'($onehot0(rf_out1_en)), 32'd1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sel_onehot(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : (32'd1 << idx);
  endfunction

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(negedge clk);
    #1 pre_we = 1'b0;
    ref_rf[idx] = val;
  endtask

  task automatic set_fields(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic we, input logic [31:0] wd);
    bus.rs1_idx[r] = rs1;
    bus.rs2_idx[r] = rs2;
    bus.rd_idx[r]  = rd;
    bus.rd_we[r]   = we;
    bus.wdata[r]   = wd;
    bus.req[r]     = 1'b1;
  endtask

  // Request goes up during IDLE cycle N; ack is then visible in cycle N+2 (N+3 with a write),
  // i.e. first sampled by edge N+3 (N+4), counting the edge that opens cycle N.
  task automatic do_txn(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic [31:0] wd);
    logic [31:0] exp1, exp2, load_vec, load_wd, en0_seen, en1_seen, ack_seen;
    logic        writes, done;
    int          lat, loads;
    writes   = we && (rd != 5'd0);
    exp1     = (rs1 == 5'd0) ? 32'd0 : ref_rf[rs1];
    exp2     = (rs2 == 5'd0) ? 32'd0 : ref_rf[rs2];
    load_vec = '0; load_wd = '0; en0_seen = '0; en1_seen = '0; ack_seen = '0;
    lat = 0; loads = 0; done = 1'b0;
    @(negedge clk);
    set_fields(r, rs1, rs2, rd, we, wd);
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (rf_load != 0) begin
        loads++;
        load_vec = rf_load;
        load_wd  = rf_wdata;
      end
      en0_seen = en0_seen | rf_out0_en;
      en1_seen = en1_seen | rf_out1_en;
      if (bus.ack != 2'b00) begin
        done     = 1'b1;
        ack_seen = 32'(bus.ack);
      end
    end
    check_eq("txn_done", 32'(done), 32'd1);
    check_eq("latency",  32'(lat), writes ? 32'd3 : 32'd2);
    check_eq("ack_who",  ack_seen, 32'(2'b01 << r));
    check_eq("rdata1",   bus.rdata1, exp1);
    check_eq("rdata2",   bus.rdata2, exp2);
    check_eq("load_cnt", 32'(loads), writes ? 32'd1 : 32'd0);
    check_eq("load_vec", load_vec, writes ? sel_onehot(rd) : 32'd0);
    check_eq("load_wd",  load_wd,  writes ? wd : 32'd0);
    check_eq("en0",      en0_seen, sel_onehot(rs1));
    check_eq("en1",      en1_seen, sel_onehot(rs2));
    bus.req[r] = 1'b0;
    if (writes) ref_rf[rd] = wd;
    @(negedge clk);
    check_eq("ack_pulse", 32'(bus.ack), 32'd0);
  endtask

  initial begin
    logic [4:0]  f_rs1 [2];
    logic [4:0]  f_rs2 [2];
    logic [31:0] wd;
    int          last_w, exp_w, acks, cyc, prev_cyc;
    reset_n = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    bus.req = '0; bus.rs1_idx = '0; bus.rs2_idx = '0; bus.rd_idx = '0;
    bus.rd_we = '0; bus.wdata = '0;
    for (int i = 0; i < 32; i++) preload(5'(i), $urandom);

    check_eq("rst_ack",   32'(bus.ack), 32'd0);
    check_eq("rst_rd1",   bus.rdata1, 32'd0);
    check_eq("rst_rd2",   bus.rdata2, 32'd0);
    check_eq("rst_load",  rf_load, 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_en0",   rf_out0_en, 32'd0);
    check_eq("rst_en1",   rf_out1_en, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Plain read, read-before-write, x0 rules
    preload(5'd3, 32'h1111_1111);
    preload(5'd5, 32'h2222_2222);
    do_txn(1'b0, 5'd3, 5'd5, 5'd0, 1'b0, 32'd0);
    preload(5'd7, 32'd0);
    do_txn(1'b0, 5'd7, 5'd0, 5'd7, 1'b1, 32'hDEAD_BEEF);
    do_txn(1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 32'd0);
    do_txn(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 32'hFFFF_FFFF);

    for (int n = 0; n < 40; n++)
      do_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             1'($urandom_range(0, 1)), $urandom);

    // Reset sampled at the edge ending READ of a write to x9
    @(negedge clk);
    set_fields(1'b0, 5'd1, 5'd2, 5'd9, 1'b1, ~ref_rf[9]);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_load", rf_load, 32'd0);
    check_eq("mid_rst_ack",  32'(bus.ack), 32'd0);
    check_eq("mid_rst_en0",  rf_out0_en, 32'd0);
    check_eq("mid_rst_rd1",  bus.rdata1, 32'd0);
    bus.req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("mid_rst_noack", 32'(bus.ack), 32'd0);
      check_eq("mid_rst_noload", rf_load, 32'd0);
    end
    check_eq("mid_rst_x9", rf_phys[9], ref_rf[9]);

    // Both requesters held for six reads
    for (int r = 0; r < 2; r++) begin
      f_rs1[r] = 5'($urandom_range(1, 31));
      f_rs2[r] = 5'($urandom_range(0, 31));
      set_fields(1'(r), f_rs1[r], f_rs2[r], 5'd0, 1'b0, 32'd0);
    end
    last_w = 1; acks = 0; cyc = 0; prev_cyc = 0;
    while (acks < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != 2'b00) begin
`ifdef REGACC_ROUND_ROBIN_EN
        exp_w = (last_w + 1) % 2;
`else
        exp_w = 0;
`endif
        check_eq("arb_ack", 32'(bus.ack), 32'(1) << exp_w);
        check_eq("arb_gap", 32'(cyc - prev_cyc), (acks == 0) ? 32'd2 : 32'd3);
        check_eq("arb_rd1", bus.rdata1, (f_rs1[exp_w] == 0) ? 32'd0 : ref_rf[f_rs1[exp_w]]);
        check_eq("arb_rd2", bus.rdata2, (f_rs2[exp_w] == 0) ? 32'd0 : ref_rf[f_rs2[exp_w]]);
        last_w   = exp_w;
        prev_cyc = cyc;
        acks++;
      end
    end
    check_eq("arb_count", 32'(acks), 32'd6);
    bus.req = '0;
    @(negedge clk);

    wd = $urandom;
    do_txn(1'b1, 5'd9, 5'd3, 5'd12, 1'b1, wd);
    do_txn(1'b0, 5'd12, 5'd9, 5'd0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
